// File: rtl/control_sequencer_pkg.sv
// Shared opcode and state encodings for the control sequencer, its datapath bench
// and future decoder logic.
package control_sequencer_pkg;

   typedef enum logic [1:0] {
      OpLoada = 2'b00,
      OpMove  = 2'b01,
      OpAdd   = 2'b10,
      OpAcc   = 2'b11
   } op_e;

   // Encodings 6 and 7 are unused and recover to StIdle.
   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StS1   = 3'd1,
      StS2   = 3'd2,
      StS3   = 3'd3,
      StS4   = 3'd4,
      StDone = 3'd5
   } state_e;

   localparam int unsigned DefCntW = 4;

endpackage

// File: rtl/control_sequencer_step_counter.sv
// Iteration counter for ACC: counts completed additions and flags the last one.
module step_counter #(
   parameter int unsigned CNT_W = 4
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             clr,
   input  logic             inc,
   input  logic [CNT_W-1:0] n,
   output logic [CNT_W-1:0] count,
   output logic             last
);

   logic [CNT_W-1:0] n_eff;

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc) begin
         count <= count + CNT_W'(1);
      end
   end

   // One extra bit so n = 2^CNT_W-1 is reached without wrap in the compare.
   always_comb begin
      n_eff = (n == '0) ? CNT_W'(1) : n;
      last  = (({1'b0, count} + (CNT_W + 1)'(1)) == {1'b0, n_eff});
   end

endmodule

// File: rtl/control_sequencer.sv
// Timing/control FSM that sequences datapath load enables and one-hot bus selects
// for one operation per start handshake.
module control_sequencer
   import control_sequencer_pkg::*;
#(
   parameter int unsigned CNT_W = DefCntW
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [CNT_W-1:0] n,
   output logic             RAin,
   output logic             RBin,
   output logic             RZin,
   output logic             RAout,
   output logic             RBout,
   output logic             RZout,
   output logic             busy,
   output logic             done
);

   state_e           state_q, state_d;
   op_e              op_q;
   logic [CNT_W-1:0] n_q;
   logic [CNT_W-1:0] count;
   logic             accept;
   logic             step_inc;
   logic             last;

   assign accept   = (state_q == StIdle) && start;
   assign step_inc = (state_q == StS2) || (state_q == StS4);

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state_q <= StIdle;
         op_q    <= OpLoada;
         n_q     <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q <= op_e'(op);
            n_q  <= n;
         end
      end
   end

   step_counter #(
      .CNT_W(CNT_W)
   ) u_step_counter (
      .clock(clock),
      .clear(clear),
      .clr  (accept),
      .inc  (step_inc),
      .n    (n_q),
      .count(count),
      .last (last)
   );

   always_comb begin
      state_d = StIdle;
      case (state_q)
         StIdle: state_d = start ? StS1 : StIdle;
         StS1: begin
            if ((op_q == OpLoada) || (op_q == OpMove)) begin
               state_d = StDone;
            end else begin
               state_d = StS2;
            end
         end
         StS2: begin
            if ((op_q == OpAcc) && !last) begin
               state_d = StS3;
            end else begin
               state_d = StDone;
            end
         end
         StS3:    state_d = StS4;
         StS4:    state_d = last ? StDone : StS3;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Moore decode of state/op flops only; at most one *out per state.
   always_comb begin
      RAin  = 1'b0;
      RBin  = 1'b0;
      RZin  = 1'b0;
      RAout = 1'b0;
      RBout = 1'b0;
      RZout = 1'b0;
      done  = 1'b0;
      busy  = (state_q != StIdle);
      case (state_q)
         StS1: begin
            if (op_q == OpLoada) begin
               RAin = 1'b1;
            end else begin
               RAout = 1'b1;
               if (op_q == OpMove) begin
                  RBin = 1'b1;
               end else begin
                  RZin = 1'b1;
               end
            end
         end
         StS2: begin
            RZout = 1'b1;
            RBin  = 1'b1;
         end
         StS3: begin
            RBout = 1'b1;
            RZin  = 1'b1;
         end
         StS4: begin
            RZout = 1'b1;
            RBin  = 1'b1;
         end
         StDone:  done = 1'b1;
         default: ;
      endcase
   end

   logic unused_count;
   assign unused_count = ^count;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench: control_sequencer driving a small datapath (A=3, imm=5, RB starts at 0).
module tb_control_sequencer;

   localparam int unsigned CNT_W = 4;
   localparam logic [7:0] A_VAL = 8'd3;
   localparam logic [7:0] IMM   = 8'd5;

   logic             clock = 1'b0;
   logic             clear = 1'b1;
   logic             start = 1'b0;
   logic [1:0]       op    = 2'b00;
   logic [CNT_W-1:0] n     = '0;
   logic RAin, RBin, RZin, RAout, RBout, RZout, busy, done;

   int tests = 0;
   int fails = 0;

   control_sequencer #(
      .CNT_W(CNT_W)
   ) dut (
      .clock(clock),
      .clear(clear),
      .start(start),
      .op   (op),
      .n    (n),
      .RAin (RAin),
      .RBin (RBin),
      .RZin (RZin),
      .RAout(RAout),
      .RBout(RBout),
      .RZout(RZout),
      .busy (busy),
      .done (done)
   );

   always #5 clock = ~clock;

   // Datapath model: registers are not touched by clear.
   logic [7:0] ra = 8'd0;
   logic [7:0] rb = 8'd0;
   logic [7:0] rz = 8'd0;
   logic [7:0] bus;
   assign bus = RAout ? ra : (RBout ? rb : (RZout ? rz : 8'd0));

   always @(posedge clock) begin
      if (RAin) ra <= IMM;
      if (RBin) rb <= bus;
      if (RZin) rz <= A_VAL + bus;
   end

   task automatic check(input string name, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // Per-cycle invariants on every test.
   logic prev_done = 1'b0;
   always @(negedge clock) begin
      if (!clear) begin
         check("onehot_out", int'(RAout) + int'(RBout) + int'(RZout) <= 1, 1);
         if (!busy) begin
            check("idle_no_enable", int'({RAin, RBin, RZin, RAout, RBout, RZout, done}), 0);
         end
         check("done_one_cycle", int'(prev_done && done), 0);
         prev_done = done;
      end else begin
         prev_done = 1'b0;
      end
   end

   typedef struct {
      string      name;
      logic [1:0] op;
      logic [3:0] n;
      logic [7:0] exp_rb;
      int         exp_lat;
      bit         poke;
   } vec_t;

   vec_t vecs[6];

   task automatic issue(input logic [1:0] o, input logic [3:0] cnt);
      op    = o;
      n     = cnt;
      start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
   endtask

   initial begin
      vecs[0] = '{"loada", 2'b00, 4'd0, 8'd0, 2, 1'b0};
      vecs[1] = '{"move", 2'b01, 4'd0, 8'd5, 2, 1'b0};
      vecs[2] = '{"add", 2'b10, 4'd0, 8'd8, 3, 1'b0};
      vecs[3] = '{"acc3", 2'b11, 4'd3, 8'd14, 7, 1'b0};
      vecs[4] = '{"acc0", 2'b11, 4'd0, 8'd8, 3, 1'b0};
      vecs[5] = '{"acc15", 2'b11, 4'd15, 8'd50, 31, 1'b1};

      #1;
      check("rst_outputs", int'({RAin, RBin, RZin, RAout, RBout, RZout}), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      @(negedge clock);
      clear = 1'b0;
      @(negedge clock);

      for (int v = 0; v < 6; v++) begin
         int lat;
         int busy_cycles;
         lat = 0;
         busy_cycles = 0;
         op    = vecs[v].op;
         n     = vecs[v].n;
         start = 1'b1;
         @(posedge clock);
         while (lat < 40) begin
            @(negedge clock);
            lat++;
            if (lat == 1) start = 1'b0;
            if (vecs[v].poke && lat == 3) begin
               start = 1'b1;
               op    = 2'b00;
            end
            if (vecs[v].poke && lat == 4) start = 1'b0;
            if (busy) busy_cycles++;
            if (done) break;
         end
         check({vecs[v].name, "_latency"}, lat, vecs[v].exp_lat);
         check({vecs[v].name, "_busy_cycles"}, busy_cycles, vecs[v].exp_lat);
         check({vecs[v].name, "_rb"}, int'(rb), int'(vecs[v].exp_rb));
         check({vecs[v].name, "_ra"}, int'(ra), int'(IMM));
         @(negedge clock);
         check({vecs[v].name, "_idle_after"}, int'({busy, done}), 0);
      end

      // Clear mid-ACC while in S3.
      begin
         int waited;
         logic [7:0] rb_snap;
         waited = 0;
         issue(2'b11, 4'd3);
         while (!RBout && waited < 20) begin
            @(negedge clock);
            waited++;
         end
         check("reach_s3", int'(RBout), 1);
         rb_snap = rb;
         check("rb_at_s3", int'(rb_snap), 8);
         #2 clear = 1'b1;
         #1;
         check("clr_outputs", int'({RAin, RBin, RZin, RAout, RBout, RZout}), 0);
         check("clr_busy", int'(busy), 0);
         check("clr_done", int'(done), 0);
         @(negedge clock);
         clear = 1'b0;
         for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            check("clr_stays_idle", int'(busy), 0);
            check("clr_rb_unchanged", int'(rb), int'(rb_snap));
         end
      end

      // ACC n=1 after clear: counter must restart from zero.
      begin
         int lat;
         lat = 0;
         op    = 2'b11;
         n     = 4'd1;
         start = 1'b1;
         @(posedge clock);
         while (lat < 40) begin
            @(negedge clock);
            lat++;
            start = 1'b0;
            if (done) break;
         end
         check("acc1_latency", lat, 3);
         check("acc1_rb", int'(rb), 8);
      end

      @(negedge clock);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
